sprite_palette_arbiter: RTL and testbench
=========================================

Name: sprite_palette_arbiter

Overview:
Shares one 16-entry sprite palette lookup among NUM_LAYERS sprite renderers (tanks, enemies, bullets) on the VGA pixel path. Each pixel, it selects the highest-priority non-transparent layer, drives the shared palette index, and registers the returned 12-bit colour. If no layer covers the pixel, it passes a background colour through. It also schedules per-layer hit-flash effects, which substitute a flash index for N frames in a blink pattern.

Parameters:
NUM_LAYERS, 4, number of sprite requesters; layer 0 has highest priority.
TRANSPARENT_IDX, 0, palette index treated as "no pixel".
FLASH_IDX, 11, substitute index while a layer's flash is in the on phase.
FLASH_FRAMES, 16, frames a flash lasts after a hit; range 1..255.
FLASH_PERIOD, 2, frames per blink half-period; range 1..255.

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse, once per frame
pixel_valid  in  1  current pixel is in the active display area
layer_valid  in  NUM_LAYERS  layer i claims the current pixel
layer_index  in  4*NUM_LAYERS  palette index of layer i; bits [4i+3:4i]
hit  in  NUM_LAYERS  one-cycle pulse that starts or restarts the flash on layer i
bg_red, bg_green, bg_blue  in  4 each  background colour for the current pixel
pal_index  out  4  index to the shared palette; registered
pal_red, pal_green, pal_blue  in  4 each  combinational palette return for pal_index
red, green, blue  out  4 each  final pixel colour; registered
vga_valid  out  1  pixel_valid delayed 2 cycles
layer_sel  out  clog2(NUM_LAYERS)  winning layer, aligned with red/green/blue
layer_hit  out  1  a layer won this pixel, aligned with red/green/blue
flashing  out  NUM_LAYERS  flash counter of layer i is nonzero

Behaviour:
- Reset, asynchronous: all outputs and all state go to 0. This covers pal_index, RGB, vga_valid, layer_sel, layer_hit, flashing, flash counters, phase counter and blink.
- Stage 1 (inputs sampled at edge N):
  - Layer i is eligible when layer_valid[i]=1 and layer_index[i] != TRANSPARENT_IDX.
  - The winner is the lowest eligible i.
  - pal_index <= FLASH_IDX if the winner's flash counter is nonzero and blink=1; otherwise pal_index <= the winner's index.
  - If no layer is eligible, pal_index <= 0.
  - Eligibility uses the original index; a transparent pixel never flashes.
  - Also registered at this stage: pixel_valid, any-eligible, winner id, bg colour.
- Stage 2 (edge N+1):
  - pixel_valid_d=0: red/green/blue <= 0.
  - Else, a winner exists: red/green/blue <= pal_red/green/blue.
  - Else: red/green/blue <= bg_d.
  - vga_valid, layer_sel and layer_hit update with the colour. layer_sel=0 and layer_hit=0 when there is no winner.
  - Total latency: 2 cycles; throughput: 1 pixel per clock with no stalls.
- Flash counters (8-bit each):
  - hit[i] loads FLASH_FRAMES.
  - Otherwise frame_start decrements the counter if it is nonzero; it saturates at 0.
  - hit[i] and frame_start in the same cycle: the load wins, with no decrement that cycle.
  - A hit while flashing restarts the count.
  - flashing[i] = (counter != 0), registered from the counter.
- Blink scheduler (global):
  - On frame_start, phase_cnt increments.
  - When phase_cnt reaches FLASH_PERIOD-1 and frame_start occurs, phase_cnt <= 0 and blink toggles.
  - With FLASH_PERIOD=1, blink toggles on every frame_start.
  - Blink runs continuously regardless of any flash activity.
- The flash substitution decision uses counter and blink values from before the edge, i.e. the same-edge view as pixel sampling.
- Reset mid-frame: pipeline contents are discarded. The first valid output appears 2 cycles after the first sampled pixel_valid=1 following deassertion.
- Unused layer_index bits are ignored whenever layer_valid=0.

Test Plan:
- Priority: layer_valid=4'b0110, idx1=3, idx2=1, pixel_valid=1 -> two cycles later pal_index was 3, RGB=7,3,2, layer_sel=1, layer_hit=1, vga_valid=1.
- Transparency: layer_valid=4'b0011, idx0=0, idx1=1 -> RGB=D,7,5, layer_sel=1; with every valid layer at idx 0 -> RGB=bg (5,A,C), layer_hit=0.
- Blanking: pixel_valid=0 with layer 0 at idx 2 -> RGB=0,0,0 and vga_valid=0 after 2 cycles; streaming check that output[k] matches input[k-2] for 20 consecutive pixels.
- Flash: hit[0] pulse, then 16 frame_starts with layer 0 at idx 3. RGB alternates between 7,3,2 and F,E,E every 2 frames during blink=1 phases. flashing[0] falls exactly at the 16th frame_start, and colour is 7,3,2 thereafter.
- Simultaneous / retrigger: hit[2] and frame_start in the same cycle -> counter=16, not 15; a second hit at count 5 -> counter reloads to 16.
- Async reset: assert reset_n low mid-line while flashing -> all outputs 0 immediately without a clock edge, flashing=0, blink=0 after release.

Source files
------------

// File: rtl/sprite_palette_arbiter.sv
// Sprite palette arbiter: picks the highest-priority opaque sprite layer per pixel,
// shares one palette lookup among layers, and overlays per-layer hit-flash blinking.
module sprite_palette_arbiter #(
  parameter int NUM_LAYERS      = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int FLASH_IDX       = 11,
  parameter int FLASH_FRAMES    = 16,
  parameter int FLASH_PERIOD    = 2,
  localparam int SEL_W          = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_start,
  input  logic                    pixel_valid,
  input  logic [NUM_LAYERS-1:0]   layer_valid,
  input  logic [4*NUM_LAYERS-1:0] layer_index,
  input  logic [NUM_LAYERS-1:0]   hit,
  input  logic [3:0]              bg_red,
  input  logic [3:0]              bg_green,
  input  logic [3:0]              bg_blue,
  output logic [3:0]              pal_index,
  input  logic [3:0]              pal_red,
  input  logic [3:0]              pal_green,
  input  logic [3:0]              pal_blue,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic                    vga_valid,
  output logic [SEL_W-1:0]        layer_sel,
  output logic                    layer_hit,
  output logic [NUM_LAYERS-1:0]   flashing
);

  logic [7:0]       flash_cnt      [NUM_LAYERS];
  logic [7:0]       flash_cnt_next [NUM_LAYERS];
  logic [7:0]       phase_cnt;
  logic             blink;

  logic             any_elig;
  logic [SEL_W-1:0] win_id;
  logic [3:0]       win_idx;
  logic [3:0]       stage1_idx;

  logic             pv_d;
  logic             any_d;
  logic [SEL_W-1:0] win_d;
  logic [11:0]      bg_d;

  // Scanning from the top down lets the lowest eligible layer overwrite the others.
  always_comb begin
    any_elig = 1'b0;
    win_id   = '0;
    win_idx  = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_valid[i] && (layer_index[4*i +: 4] != 4'(TRANSPARENT_IDX))) begin
        any_elig = 1'b1;
        win_id   = SEL_W'(i);
        win_idx  = layer_index[4*i +: 4];
      end
    end
  end

  always_comb begin
    stage1_idx = 4'd0;
    if (any_elig) begin
      if ((flash_cnt[win_id] != 8'd0) && blink) begin
        stage1_idx = 4'(FLASH_IDX);
      end else begin
        stage1_idx = win_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pal_index <= 4'd0;
      pv_d      <= 1'b0;
      any_d     <= 1'b0;
      win_d     <= '0;
      bg_d      <= 12'd0;
    end else begin
      pal_index <= stage1_idx;
      pv_d      <= pixel_valid;
      any_d     <= any_elig;
      win_d     <= win_id;
      bg_d      <= {bg_red, bg_green, bg_blue};
    end
  end

  // Blanked pixels report no winner so layer_sel/layer_hit never describe invisible pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red       <= 4'd0;
      green     <= 4'd0;
      blue      <= 4'd0;
      vga_valid <= 1'b0;
      layer_sel <= '0;
      layer_hit <= 1'b0;
    end else begin
      vga_valid <= pv_d;
      if (!pv_d) begin
        {red, green, blue} <= 12'd0;
        layer_sel          <= '0;
        layer_hit          <= 1'b0;
      end else if (any_d) begin
        {red, green, blue} <= {pal_red, pal_green, pal_blue};
        layer_sel          <= win_d;
        layer_hit          <= 1'b1;
      end else begin
        {red, green, blue} <= bg_d;
        layer_sel          <= '0;
        layer_hit          <= 1'b0;
      end
    end
  end

  // A hit reloads the counter and suppresses that frame's decrement.
  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      flash_cnt_next[i] = flash_cnt[i];
      if (hit[i]) begin
        flash_cnt_next[i] = 8'(FLASH_FRAMES);
      end else if (frame_start && (flash_cnt[i] != 8'd0)) begin
        flash_cnt_next[i] = flash_cnt[i] - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        flash_cnt[i] <= 8'd0;
      end
      flashing <= '0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        flash_cnt[i] <= flash_cnt_next[i];
        flashing[i]  <= (flash_cnt_next[i] != 8'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt <= 8'd0;
      blink     <= 1'b0;
    end else if (frame_start) begin
      if (phase_cnt == 8'(FLASH_PERIOD - 1)) begin
        phase_cnt <= 8'd0;
        blink     <= ~blink;
      end else begin
        phase_cnt <= phase_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Directed bench for sprite_palette_arbiter: table-driven pixel vectors streamed back to back,
// plus hand-written flash, retrigger and asynchronous-reset sequences.
module tb_sprite_palette_arbiter;

  typedef struct {
    logic [3:0]  lv;
    logic [15:0] idx;
    logic        pv;
    logic [11:0] bg;
    logic [11:0] rgb;
    logic [1:0]  sel;
    logic        hit;
    logic        vv;
  } vec_t;

  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic        pixel_valid;
  logic [3:0]  layer_valid;
  logic [15:0] layer_index;
  logic [3:0]  hit;
  logic [3:0]  bg_red, bg_green, bg_blue;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        vga_valid;
  logic [1:0]  layer_sel;
  logic        layer_hit;
  logic [3:0]  flashing;

  logic [11:0] pal_rom [16];
  vec_t        vecs [NV];
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  assign {pal_red, pal_green, pal_blue} = pal_rom[pal_index];

  sprite_palette_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .layer_valid (layer_valid),
    .layer_index (layer_index),
    .hit         (hit),
    .bg_red      (bg_red),
    .bg_green    (bg_green),
    .bg_blue     (bg_blue),
    .pal_index   (pal_index),
    .pal_red     (pal_red),
    .pal_green   (pal_green),
    .pal_blue    (pal_blue),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .vga_valid   (vga_valid),
    .layer_sel   (layer_sel),
    .layer_hit   (layer_hit),
    .flashing    (flashing)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    layer_valid = v.lv;
    layer_index = v.idx;
    pixel_valid = v.pv;
    {bg_red, bg_green, bg_blue} = v.bg;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkVector(input string name, input vec_t v);
    checkOutput({name, " rgb"}, 32'({red, green, blue}), 32'(v.rgb));
    checkOutput({name, " vga_valid"}, 32'(vga_valid), 32'(v.vv));
    checkOutput({name, " layer_sel"}, 32'(layer_sel), 32'(v.sel));
    checkOutput({name, " layer_hit"}, 32'(layer_hit), 32'(v.hit));
  endtask

  task automatic frameStart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic setPixel(input logic [3:0] lv, input logic [15:0] idx);
    layer_valid = lv;
    layer_index = idx;
    pixel_valid = 1'b1;
    {bg_red, bg_green, bg_blue} = 12'h000;
  endtask

  initial begin
    pal_rom = '{12'h000, 12'hD75, 12'h9A1, 12'h732, 12'h123, 12'h456, 12'h789, 12'hABC,
                12'h222, 12'h333, 12'h444, 12'hFEE, 12'h555, 12'h666, 12'h777, 12'h888};

    //          lv       idx       pv    bg       rgb      sel   hit   vv
    vecs[0]  = '{4'b0110, 16'h0130, 1'b1, 12'h5AC, 12'h732, 2'd1, 1'b1, 1'b1};
    vecs[1]  = '{4'b0011, 16'h0010, 1'b1, 12'h5AC, 12'hD75, 2'd1, 1'b1, 1'b1};
    vecs[2]  = '{4'b1111, 16'h0000, 1'b1, 12'h5AC, 12'h5AC, 2'd0, 1'b0, 1'b1};
    vecs[3]  = '{4'b0001, 16'h0002, 1'b0, 12'h5AC, 12'h000, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{4'b1000, 16'h5000, 1'b1, 12'h5AC, 12'h456, 2'd3, 1'b1, 1'b1};
    vecs[5]  = '{4'b1100, 16'h4F00, 1'b1, 12'h5AC, 12'h888, 2'd2, 1'b1, 1'b1};
    vecs[6]  = '{4'b0000, 16'h1234, 1'b1, 12'h123, 12'h123, 2'd0, 1'b0, 1'b1};
    vecs[7]  = '{4'b1111, 16'h9867, 1'b1, 12'h5AC, 12'hABC, 2'd0, 1'b1, 1'b1};
    vecs[8]  = '{4'b1110, 16'h9004, 1'b1, 12'h5AC, 12'h333, 2'd3, 1'b1, 1'b1};
    vecs[9]  = '{4'b0101, 16'h0C00, 1'b1, 12'h5AC, 12'h555, 2'd2, 1'b1, 1'b1};
    vecs[10] = '{4'b0000, 16'h0000, 1'b0, 12'hFFF, 12'h000, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{4'b0010, 16'h00B0, 1'b1, 12'h5AC, 12'hFEE, 2'd1, 1'b1, 1'b1};
    vecs[12] = '{4'b1111, 16'h1111, 1'b1, 12'h5AC, 12'hD75, 2'd0, 1'b1, 1'b1};
    vecs[13] = '{4'b0001, 16'h0006, 1'b1, 12'h000, 12'h789, 2'd0, 1'b1, 1'b1};

    reset_n = 1'b0;
    frame_start = 1'b0;
    hit = 4'd0;
    setPixel(4'b0001, 16'h0003);
    tick();
    tick();
    checkOutput("reset rgb", 32'({red, green, blue}), 32'h0);
    checkOutput("reset pal_index", 32'(pal_index), 32'h0);
    checkOutput("reset vga_valid", 32'(vga_valid), 32'h0);
    checkOutput("reset layer_hit", 32'(layer_hit), 32'h0);
    checkOutput("reset flashing", 32'(flashing), 32'h0);
    reset_n = 1'b1;
    pixel_valid = 1'b0;
    tick();

    $display("[TB] isolated priority pixel");
    applyStimulus(vecs[0]);
    tick();
    checkOutput("priority pal_index", 32'(pal_index), 32'd3);
    applyStimulus(vecs[10]);
    tick();
    checkVector("priority", vecs[0]);

    $display("[TB] streaming vectors");
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) applyStimulus(vecs[k % NV]);
      else applyStimulus(vecs[10]);
      tick();
      if (k >= 1) checkVector($sformatf("stream%0d", k - 1), vecs[(k - 1) % NV]);
    end

    $display("[TB] flash sequence on layer 0");
    doReset();
    setPixel(4'b0001, 16'h0003);
    hit = 4'b0001;
    tick();
    hit = 4'b0000;
    tick();
    tick();
    checkOutput("flash k0 rgb", 32'({red, green, blue}), 32'h732);
    checkOutput("flash k0 flashing", 32'(flashing[0]), 32'd1);
    for (int k = 1; k <= 18; k++) begin
      frameStart();
      checkOutput($sformatf("flash k%0d flashing", k), 32'(flashing[0]), 32'(k < 16));
      tick();
      tick();
      checkOutput($sformatf("flash k%0d rgb", k), 32'({red, green, blue}),
                  ((k < 16) && (((k / 2) % 2) == 1)) ? 32'hFEE : 32'h732);
    end

    $display("[TB] hit coincident with frame_start");
    doReset();
    hit = 4'b0100;
    frame_start = 1'b1;
    tick();
    hit = 4'b0000;
    frame_start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      frameStart();
      checkOutput($sformatf("coincident k%0d flashing2", k), 32'(flashing[2]), 32'(k < 16));
    end

    $display("[TB] retrigger while flashing");
    hit = 4'b0010;
    tick();
    hit = 4'b0000;
    for (int k = 1; k <= 11; k++) frameStart();
    checkOutput("retrigger at 5 flashing1", 32'(flashing[1]), 32'd1);
    hit = 4'b0010;
    tick();
    hit = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      frameStart();
      checkOutput($sformatf("retrigger k%0d flashing1", k), 32'(flashing[1]), 32'(k < 16));
    end

    $display("[TB] asynchronous reset while flashing");
    doReset();
    frameStart();
    frameStart();
    setPixel(4'b0001, 16'h0003);
    hit = 4'b0001;
    tick();
    hit = 4'b0000;
    tick();
    tick();
    checkOutput("pre-reset flash rgb", 32'({red, green, blue}), 32'hFEE);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async rgb", 32'({red, green, blue}), 32'h0);
    checkOutput("async vga_valid", 32'(vga_valid), 32'h0);
    checkOutput("async layer_hit", 32'(layer_hit), 32'h0);
    checkOutput("async pal_index", 32'(pal_index), 32'h0);
    checkOutput("async flashing", 32'(flashing), 32'h0);
    #1;
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("post-reset rgb", 32'({red, green, blue}), 32'h732);
    checkOutput("post-reset flashing", 32'(flashing), 32'h0);
    hit = 4'b0001;
    tick();
    hit = 4'b0000;
    tick();
    tick();
    checkOutput("post-reset blink low rgb", 32'({red, green, blue}), 32'h732);
    checkOutput("post-reset flashing0", 32'(flashing[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
